// File: rtl/upd_arb_2.sv
// rtl/upd_arb_2.sv - two-source update arbiter with per-source FIFOs and round-robin one-hot load output
module upd_arb_2 #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clkrst_core_clk,
  input  logic             clkrst_core_rst_n,
  input  logic             s0_valid,
  input  logic [WIDTH-1:0] s0_data,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [WIDTH-1:0] s1_data,
  output logic             s1_ready,
  input  logic             hold,
  output logic             out_en0,
  output logic             out_en1,
  output logic [WIDTH-1:0] out_d0,
  output logic [WIDTH-1:0] out_d1,
  output logic             busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem0 [DEPTH];
  logic [WIDTH-1:0] mem1 [DEPTH];
  logic [PW-1:0]    wptr0, rptr0, wptr1, rptr1;
  logic [CW-1:0]    count0, count1, count0_nxt, count1_nxt;
  logic             last;
  logic             push0, push1, elig0, elig1, grant0, grant1;

  // Ready looks only at stored occupancy, so a full FIFO refuses even while popping.
  assign s0_ready = (count0 != CW'(DEPTH));
  assign s1_ready = (count1 != CW'(DEPTH));
  assign push0    = s0_valid & s0_ready;
  assign push1    = s1_valid & s1_ready;

  assign elig0  = (count0 != '0) & ~hold;
  assign elig1  = (count1 != '0) & ~hold;
  // On a tie the source that did not win last time is served.
  assign grant0 = elig0 & (~elig1 | last);
  assign grant1 = elig1 & (~elig0 | ~last);

  always_comb begin
    count0_nxt = count0;
    count1_nxt = count1;
    if (push0 & ~grant0)      count0_nxt = count0 + CW'(1);
    else if (~push0 & grant0) count0_nxt = count0 - CW'(1);
    if (push1 & ~grant1)      count1_nxt = count1 + CW'(1);
    else if (~push1 & grant1) count1_nxt = count1 - CW'(1);
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (push0) mem0[wptr0] <= s0_data;
    if (push1) mem1[wptr1] <= s1_data;
  end

  always_ff @(posedge clkrst_core_clk) begin
    if (!clkrst_core_rst_n) begin
      wptr0   <= '0;
      rptr0   <= '0;
      wptr1   <= '0;
      rptr1   <= '0;
      count0  <= '0;
      count1  <= '0;
      last    <= 1'b1;
      out_en0 <= 1'b0;
      out_en1 <= 1'b0;
      out_d0  <= '0;
      out_d1  <= '0;
      busy    <= 1'b0;
    end else begin
      if (push0)  wptr0 <= wptr0 + PW'(1);
      if (push1)  wptr1 <= wptr1 + PW'(1);
      if (grant0) begin
        rptr0  <= rptr0 + PW'(1);
        out_d0 <= mem0[rptr0];
        last   <= 1'b0;
      end
      if (grant1) begin
        rptr1  <= rptr1 + PW'(1);
        out_d1 <= mem1[rptr1];
        last   <= 1'b1;
      end
      count0  <= count0_nxt;
      count1  <= count1_nxt;
      out_en0 <= grant0;
      out_en1 <= grant1;
      busy    <= (count0_nxt != '0) | (count1_nxt != '0);
    end
  end

endmodule

// File: tb/tb_upd_arb_2.sv
// tb/tb_upd_arb_2.sv - randomized and directed bench for upd_arb_2 against a queue-based reference model
module tb_upd_arb_2;
  localparam int WIDTH = 8;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s0_valid, s1_valid, hold;
  logic [WIDTH-1:0] s0_data, s1_data;
  logic             s0_ready, s1_ready;
  logic             out_en0, out_en1, busy;
  logic [WIDTH-1:0] out_d0, out_d1;

  always #5 clk = ~clk;

  upd_arb_2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clkrst_core_clk  (clk),
    .clkrst_core_rst_n(rst_n),
    .s0_valid         (s0_valid),
    .s0_data          (s0_data),
    .s0_ready         (s0_ready),
    .s1_valid         (s1_valid),
    .s1_data          (s1_data),
    .s1_ready         (s1_ready),
    .hold             (hold),
    .out_en0          (out_en0),
    .out_en1          (out_en1),
    .out_d0           (out_d0),
    .out_d1           (out_d1),
    .busy             (busy)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference state: one queue per source plus the expected registered outputs.
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  bit               m_last = 1'b1;
  logic             e_en0 = 1'b0, e_en1 = 1'b0, e_busy = 1'b0;
  logic [WIDTH-1:0] e_d0 = '0, e_d1 = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input logic rn, input logic v0, input logic [WIDTH-1:0] d0,
                     input logic v1, input logic [WIDTH-1:0] d1, input logic hld);
    bit r0, r1, el0, el1, g0, g1;
    rst_n = rn; s0_valid = v0; s0_data = d0; s1_valid = v1; s1_data = d1; hold = hld;
    #1;
    r0 = (q0.size() < DEPTH);
    r1 = (q1.size() < DEPTH);
    chk("s0_ready", 32'(s0_ready), 32'(r0));
    chk("s1_ready", 32'(s1_ready), 32'(r1));
    if (!rn) begin
      q0.delete(); q1.delete();
      m_last = 1'b1;
      e_en0 = 0; e_en1 = 0; e_d0 = '0; e_d1 = '0; e_busy = 0;
    end else begin
      el0 = (q0.size() != 0) && !hld;
      el1 = (q1.size() != 0) && !hld;
      g0  = el0 && (!el1 || m_last);
      g1  = el1 && (!el0 || !m_last);
      if (g0) begin e_d0 = q0.pop_front(); m_last = 1'b0; end
      if (g1) begin e_d1 = q1.pop_front(); m_last = 1'b1; end
      if (v0 && r0) q0.push_back(d0);
      if (v1 && r1) q1.push_back(d1);
      e_en0  = g0;
      e_en1  = g1;
      e_busy = (q0.size() != 0) || (q1.size() != 0);
    end
    @(posedge clk);
    #1;
    chk("out_en0", 32'(out_en0), 32'(e_en0));
    chk("out_en1", 32'(out_en1), 32'(e_en1));
    chk("out_d0",  32'(out_d0),  32'(e_d0));
    chk("out_d1",  32'(out_d1),  32'(e_d1));
    chk("busy",    32'(busy),    32'(e_busy));
    chk("onehot",  32'(out_en0 & out_en1), 32'd0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0; hold = 1'b0;
    s0_data = '0; s1_data = '0;
    @(posedge clk);
    #1;
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(2);

    // Word pushed just before a reset must never appear.
    cyc(1'b1, 1'b1, 8'h11, 1'b0, '0, 1'b0);
    cyc(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
    idle(3);

    // Single word, one-cycle latency.
    cyc(1'b1, 1'b1, 8'hA5, 1'b0, '0, 1'b0);
    idle(3);

    // Fairness and ordering across simultaneous pushes.
    cyc(1'b1, 1'b1, 8'h01, 1'b1, 8'h81, 1'b0);
    cyc(1'b1, 1'b1, 8'h02, 1'b1, 8'h82, 1'b0);
    idle(5);

    // Fill s1 under hold; third push rejected, then drain.
    cyc(1'b1, 1'b0, '0, 1'b1, 8'hC1, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1, 8'hC2, 1'b1);
    cyc(1'b1, 1'b0, '0, 1'b1, 8'hC3, 1'b1);
    idle(4);

    // FIFO 0 full: pop and push in the same cycle, push is ignored.
    cyc(1'b1, 1'b1, 8'hD1, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 8'hD2, 1'b0, '0, 1'b1);
    cyc(1'b1, 1'b1, 8'hD3, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b1, 8'hD4, 1'b0, '0, 1'b0);
    idle(4);

    // Pointer wrap: 10 words on s0 on alternate cycles.
    for (int i = 0; i < 20; i++)
      cyc(1'b1, (i % 2) == 0, 8'(8'h30 + i), 1'b0, '0, 1'b0);
    idle(3);

    // Randomized traffic with varying load, hold and occasional reset.
    for (int blk = 0; blk < 6; blk++) begin
      int p0, p1, ph;
      p0 = $urandom_range(10, 100);
      p1 = $urandom_range(10, 100);
      ph = $urandom_range(0, 40);
      for (int i = 0; i < 100; i++) begin
        cyc($urandom_range(0, 99) >= 2,
            $urandom_range(0, 99) < p0, 8'($urandom),
            $urandom_range(0, 99) < p1, 8'($urandom),
            $urandom_range(0, 99) < ph);
      end
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
